uart_tx_bus: RTL and testbench

- Memory-mapped UART transmitter on the core's data bus.
- Consumes the core's bus_address/bus_write_data/bus_write_enable/bus_read_enable strobes and returns bus_read_data.
- Buffers bytes in a small FIFO and serializes them 8N1 (LSB first) on tx.
- Raises an interrupt request on the core's interrupt_vector/interrupt_ack handshake when the transmitter has fully drained.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_bus_if.sv | 20 ++
 rtl/uart_fifo.sv | 51 +++++
 rtl/uart_tx_bus.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_tx_bus.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the bus-mapped UART transmitter.
// Build option: UART_PARITY_EN adds an even-parity bit (PARITY state, 11-bit frame).
package uart_pkg;

  localparam logic [4:0] OFF_TXDATA = 5'h00;
  localparam logic [4:0] OFF_STATUS = 5'h08;
  localparam logic [4:0] OFF_CTRL   = 5'h10;

  // Register index as decoded from bus_address[4:3]
  localparam logic [1:0] SEL_TXDATA = OFF_TXDATA[4:3];
  localparam logic [1:0] SEL_STATUS = OFF_STATUS[4:3];
  localparam logic [1:0] SEL_CTRL   = OFF_CTRL[4:3];

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_OVERRUN   = 2;
  localparam int unsigned STAT_EMPTY     = 3;
  localparam int unsigned STAT_COUNT_LSB = 8;

  localparam int unsigned CTRL_IRQ_EN = 0;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
  localparam int unsigned FRAME_BITS = 11;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
  localparam int unsigned FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_tx_bus_if.sv
// Core data-bus strobes seen by the UART register block.
interface uart_tx_bus_if;

  logic [63:0] bus_address;
  logic [63:0] bus_write_data;
  logic        bus_write_enable;
  logic        bus_read_enable;
  logic [63:0] bus_read_data;

  modport master (
    output bus_address, bus_write_data, bus_write_enable, bus_read_enable,
    input  bus_read_data
  );

  modport slave (
    input  bus_address, bus_write_data, bus_write_enable, bus_read_enable,
    output bus_read_data
  );

endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit so full/empty need no flag.
module uart_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [AW:0] PTR_DEPTH = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    count   = wr_ptr - rd_ptr;
    full    = (count == PTR_DEPTH);
    empty   = (wr_ptr == rd_ptr);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken
    push_ok = push && (!full || pop);
    pop_ok  = pop && !empty;
    rdata   = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_bus.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and drain interrupt.
// Build option: UART_PARITY_EN inserts an even-parity bit before STOP.
module uart_tx_bus
  import uart_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_1000_0000,
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [3:0]  IRQ_CODE   = 4'd1
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_bus_if.slave       bus,
  output logic               tx,
  output logic [3:0]         irq_vector,
  input  logic               irq_ack
);

  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BAUD_ONE  = 1;

  logic             hit;
  logic [1:0]       reg_sel;
  logic             wr_txdata;
  logic             wr_status;
  logic             wr_ctrl;

  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic [7:0]       fifo_data;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             baud_done;
  logic             frame_done;
`ifdef UART_PARITY_EN
  logic             parity_bit;
`endif

  logic             overrun;
  logic             irq_en;
  logic             pending;
  logic             pending_next;
  logic             sent;
  logic [63:0]      status_word;
  logic [63:0]      read_mux;
  logic             unused_bits;

  assign unused_bits = ^{bus.bus_write_data[63:8], bus.bus_address[2:0]};

  always_comb begin
    hit       = (bus.bus_address[63:5] == BASE_ADDR[63:5]);
    reg_sel   = bus.bus_address[4:3];
    wr_txdata = bus.bus_write_enable && hit && (reg_sel == SEL_TXDATA);
    wr_status = bus.bus_write_enable && hit && (reg_sel == SEL_STATUS);
    wr_ctrl   = bus.bus_write_enable && hit && (reg_sel == SEL_CTRL);
    push      = wr_txdata;
    baud_done  = (baud_cnt == BAUD_LAST);
    frame_done = (state == ST_STOP) && baud_done;
    pop        = !empty && ((state == ST_IDLE) || frame_done);
  end

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (bus.bus_write_data[7:0]),
    .rdata (fifo_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // tx is registered alongside the state so each bit starts on the cycle its state is entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
`ifdef UART_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (!empty) begin
            shift   <= fifo_data;
            bit_cnt <= '0;
            tx      <= 1'b0;
            state   <= ST_START;
`ifdef UART_PARITY_EN
            parity_bit <= ^fifo_data;
`endif
          end
        end
        ST_START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx       <= shift[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
              tx    <= parity_bit;
              state <= ST_PARITY;
`else
              tx    <= 1'b1;
              state <= ST_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
`endif
        ST_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (!empty) begin
              shift   <= fifo_data;
              bit_cnt <= '0;
              tx      <= 1'b0;
              state   <= ST_START;
`ifdef UART_PARITY_EN
              parity_bit <= ^fifo_data;
`endif
            end else begin
              tx    <= 1'b1;
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        default: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    pending_next = pending;
    if (frame_done && empty && irq_en && sent) pending_next = 1'b1;
    if (irq_ack && pending)                    pending_next = 1'b0;
    if (wr_ctrl && !bus.bus_write_data[CTRL_IRQ_EN]) pending_next = 1'b0;
  end

  always_comb begin
    status_word                          = '0;
    status_word[STAT_BUSY]               = (state != ST_IDLE);
    status_word[STAT_FULL]               = full;
    status_word[STAT_OVERRUN]            = overrun;
    status_word[STAT_EMPTY]              = empty;
    status_word[STAT_COUNT_LSB +: 8]     = 8'(count);

    read_mux = '0;
    if (hit) begin
      case (reg_sel)
        SEL_STATUS: read_mux = status_word;
        SEL_CTRL:   read_mux[CTRL_IRQ_EN] = irq_en;
        default:    read_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun           <= 1'b0;
      irq_en            <= 1'b0;
      pending           <= 1'b0;
      sent              <= 1'b0;
      irq_vector        <= '0;
      bus.bus_read_data <= '0;
    end else begin
      if (push && full && !pop) begin
        overrun <= 1'b1;
      end else if (wr_status && bus.bus_write_data[STAT_OVERRUN]) begin
        overrun <= 1'b0;
      end

      if (wr_ctrl) irq_en <= bus.bus_write_data[CTRL_IRQ_EN];

      // "Sent since last ack": only an ack that actually retires a pending request clears it
      if (pop) begin
        sent <= 1'b1;
      end else if (irq_ack && pending) begin
        sent <= 1'b0;
      end

      pending    <= pending_next;
      irq_vector <= pending_next ? IRQ_CODE : '0;

      if (bus.bus_read_enable) bus.bus_read_data <= read_mux;
    end
  end

endmodule

// File: tb/tb_uart_tx_bus.sv
// Self-checking bench for uart_tx_bus: register table, frame waveforms, FIFO/overrun,
// interrupt handshake and mid-frame reset, with a tx-line decoder as byte scoreboard.
module tb_uart_tx_bus;

  localparam logic [63:0] BASE  = 64'h0000_0000_1000_0000;
  localparam int unsigned DIV   = 4;
  localparam int unsigned DEPTH = 8;

  localparam logic [63:0] A_TX   = BASE + 64'h00;
  localparam logic [63:0] A_ST   = BASE + 64'h08;
  localparam logic [63:0] A_CTRL = BASE + 64'h10;
  localparam logic [63:0] A_UNM  = BASE + 64'h18;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx;
  logic [3:0] irq_vector;
  logic       irq_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       wave[$];
  logic       rst_seen = 1'b0;
  logic [7:0] mon_b;
  logic       mon_par;
  logic       mon_ok;

  typedef struct packed {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] data;   // write data, or required read value
  } vec_t;

  vec_t tbl[21];

  uart_tx_bus_if bus();

  always #5 clk = ~clk;

  uart_tx_bus #(
    .BASE_ADDR  (BASE),
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (DEPTH),
    .IRQ_CODE   (4'd1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .tx         (tx),
    .irq_vector (irq_vector),
    .irq_ack    (irq_ack)
  );

  always @(negedge reset) rst_seen = 1'b1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] status_model(input logic busy, input logic full,
                                               input logic ovr, input logic empty,
                                               input int cnt);
    logic [7:0] c;
    c = 8'(cnt);
    return {48'b0, c, 4'b0, empty, ovr, full, busy};
  endfunction

  task automatic bus_write(input logic [63:0] a, input logic [63:0] d);
    bus.bus_address      = a;
    bus.bus_write_data   = d;
    bus.bus_write_enable = 1'b1;
    @(negedge clk);
    bus.bus_write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [63:0] a, output logic [63:0] d);
    bus.bus_address     = a;
    bus.bus_read_enable = 1'b1;
    @(negedge clk);
    bus.bus_read_enable = 1'b0;
    d = bus.bus_read_data;
  endtask

  task automatic read_check(input string name, input logic [63:0] a, input logic [63:0] exp);
    logic [63:0] d;
    bus_read(a, d);
    check64(name, d, exp);
  endtask

  task automatic send(input logic [7:0] b);
    bus_write(A_TX, {56'b0, b});
    exp_q.push_back(b);
  endtask

  task automatic add_frame(input logic [7:0] b);
    repeat (DIV) wave.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (DIV) wave.push_back(b[i]);
`ifdef UART_PARITY_EN
    repeat (DIV) wave.push_back(^b);
`endif
    repeat (DIV) wave.push_back(1'b1);
  endtask

  // Samples tx on consecutive negedges against the expected line, starting now
  task automatic check_wave(input string name, input int read_at, input logic [63:0] rd_exp);
    int bad = -1;
    logic got = 1'b0;
    for (int i = 0; i < wave.size(); i++) begin
      if (bad < 0 && (tx !== wave[i] || irq_vector !== 4'd0)) begin
        bad = i;
        got = tx;
      end
      if (read_at >= 0 && i == read_at) begin
        bus.bus_address     = A_ST;
        bus.bus_read_enable = 1'b1;
      end
      if (read_at >= 0 && i == read_at + 1) begin
        bus.bus_read_enable = 1'b0;
        check64({name, "_status"}, bus.bus_read_data, rd_exp);
      end
      if (read_at >= 0 && i == read_at + 3) check64({name, "_hold"}, bus.bus_read_data, rd_exp);
      @(negedge clk);
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: cycle %0d tx=%b irq=%0d, required tx=%b irq=0",
               name, bad, got, irq_vector, wave[bad]);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2 * DIV) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d bytes never seen on tx, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_irq(input string name);
    int n = 0;
    while (irq_vector == 4'd0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check64(name, {60'b0, irq_vector}, 64'd1);
  endtask

  // Line decoder: samples mid-bit, compares each received byte with the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (reset && tx === 1'b0) begin
        rst_seen = 1'b0;
        repeat (DIV / 2) @(negedge clk);
        mon_ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          mon_b[i] = tx;
        end
        mon_par = ^mon_b;
`ifdef UART_PARITY_EN
        repeat (DIV) @(negedge clk);
        mon_par = tx;
`endif
        repeat (DIV) @(negedge clk);
        mon_ok = mon_ok && (tx === 1'b1) && (mon_par === ^mon_b);
        if (!rst_seen) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rx_byte: got unexpected %h, required no frame", mon_b);
          end else if (!mon_ok || mon_b !== exp_q[0]) begin
            errors++;
            $display("FAIL rx_byte: got %h (framing ok=%b), required %h", mon_b, mon_ok, exp_q[0]);
            void'(exp_q.pop_front());
          end else begin
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] d;
    int n, acc, in_fifo, quiet;

    bus.bus_address      = '0;
    bus.bus_write_data   = '0;
    bus.bus_write_enable = 1'b0;
    bus.bus_read_enable  = 1'b0;

    tbl[0]  = '{1'b1, A_CTRL, 64'd1};
    tbl[1]  = '{1'b0, A_CTRL, 64'd1};
    tbl[2]  = '{1'b0, A_CTRL | 64'h7, 64'd1};
    tbl[3]  = '{1'b0, 64'h8000_0000_1000_0010, 64'd0};
    tbl[4]  = '{1'b0, A_CTRL, 64'd1};
    tbl[5]  = '{1'b1, A_CTRL, 64'hFFFF_FFFF_FFFF_FFFE};
    tbl[6]  = '{1'b0, A_CTRL, 64'd0};
    tbl[7]  = '{1'b1, BASE + 64'h30, 64'd1};
    tbl[8]  = '{1'b0, A_CTRL, 64'd0};
    tbl[9]  = '{1'b1, A_UNM, 64'd1};
    tbl[10] = '{1'b0, A_CTRL, 64'd0};
    tbl[11] = '{1'b0, A_ST, 64'h8};
    tbl[12] = '{1'b0, A_TX, 64'd0};
    tbl[13] = '{1'b0, A_ST, 64'h8};
    tbl[14] = '{1'b0, A_UNM, 64'd0};
    tbl[15] = '{1'b0, A_ST | 64'h5, 64'h8};
    tbl[16] = '{1'b0, BASE + 64'h28, 64'd0};
    tbl[17] = '{1'b1, A_ST, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[18] = '{1'b0, A_ST, 64'h8};
    tbl[19] = '{1'b1, BASE + 64'h20, 64'hAB};
    tbl[20] = '{1'b0, A_ST, 64'h8};

    // Reset values
    repeat (3) @(negedge clk);
    check64("rst_tx", {63'b0, tx}, 64'd1);
    check64("rst_rdata", bus.bus_read_data, 64'd0);
    check64("rst_irq", {60'b0, irq_vector}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Register map table
    for (int i = 0; i < 21; i++) begin
      if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].data);
      else read_check($sformatf("tbl[%0d]", i), tbl[i].addr, tbl[i].data);
    end

    // Single frame 0x55 with a STATUS read during the frame
    send(8'h55);
    @(negedge clk);
    wave.delete();
    add_frame(8'h55);
    check_wave("frame_55", 10, status_model(1'b1, 1'b0, 1'b0, 1'b1, 0));
    read_check("idle_after_55", A_ST, 64'h8);

    send(8'h07);
    @(negedge clk);
    wave.delete();
    add_frame(8'h07);
    check_wave("frame_07", -1, 64'd0);
    wait_drain("drain_07");

    // Ten back-to-back pushes: nine accepted, tenth dropped
    for (int i = 0; i < 10; i++) begin
      if (i < DEPTH + 1) send(8'(8'h30 + i));
      else bus_write(A_TX, 64'hEE);
    end
    @(negedge clk);
    read_check("ovf_status", A_ST, status_model(1'b1, 1'b1, 1'b1, 1'b0, DEPTH));
    bus_write(A_ST, 64'h4);
    read_check("ovf_cleared", A_ST, status_model(1'b1, 1'b1, 1'b0, 1'b0, DEPTH));
    wait_drain("drain_ovf");

    // Random bursts from idle; model: min(n, DEPTH+1) accepted, one already in the shifter
    for (int it = 0; it < 6; it++) begin
      bus_write(A_ST, 64'h4);
      n = $urandom_range(1, 12);
      acc = (n < DEPTH + 1) ? n : DEPTH + 1;
      for (int i = 0; i < n; i++) begin
        if (i < acc) send(8'($urandom));
        else bus_write(A_TX, 64'($urandom));
      end
      @(negedge clk);
      in_fifo = acc - 1;
      read_check($sformatf("rand%0d_status", it), A_ST,
                 status_model(1'b1, in_fifo == DEPTH, n > DEPTH + 1, in_fifo == 0, in_fifo));
      wait_drain($sformatf("rand%0d_drain", it));
      read_check($sformatf("rand%0d_idle", it), A_ST, status_model(1'b0, 1'b0, n > DEPTH + 1, 1'b1, 0));
    end
    bus_write(A_ST, 64'h4);

    // Interrupt: two frames back to back, irq after the second STOP
    bus_write(A_CTRL, 64'd1);
    send(8'hA5);
    send(8'h3C);
    wave.delete();
    add_frame(8'hA5);
    add_frame(8'h3C);
    check_wave("irq_frames", -1, 64'd0);
    check64("irq_set", {60'b0, irq_vector}, 64'd1);
    repeat (3) @(negedge clk);
    check64("irq_sticky", {60'b0, irq_vector}, 64'd1);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    check64("irq_acked", {60'b0, irq_vector}, 64'd0);
    quiet = 1;
    repeat (100) begin
      @(negedge clk);
      if (irq_vector !== 4'd0) quiet = 0;
    end
    check64("irq_no_reassert", 64'(quiet), 64'd1);

    // New push while pending keeps it; clearing irq_en drops it
    send(8'h11);
    wait_irq("irq_second");
    send(8'h22);
    repeat (20) @(negedge clk);
    check64("irq_held_on_push", {60'b0, irq_vector}, 64'd1);
    bus_write(A_CTRL, 64'd0);
    check64("irq_en_clear", {60'b0, irq_vector}, 64'd0);
    wait_drain("drain_irq");

    // Reset in the middle of DATA
    bus_write(A_CTRL, 64'd1);
    send(8'hC3);
    send(8'h81);
    send(8'h18);
    read_check("pre_reset_status", A_ST, status_model(1'b1, 1'b0, 1'b0, 1'b0, 2));
    repeat (13) @(negedge clk);
    check64("pre_reset_tx", {63'b0, tx}, 64'd0);
    #2 reset = 1'b0;
    exp_q.delete();
    #1;
    check64("async_rst_tx", {63'b0, tx}, 64'd1);
    check64("async_rst_rdata", bus.bus_read_data, 64'd0);
    check64("async_rst_irq", {60'b0, irq_vector}, 64'd0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    read_check("post_reset_status", A_ST, 64'h8);
    read_check("post_reset_ctrl", A_CTRL, 64'd0);
    quiet = 1;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || irq_vector !== 4'd0) quiet = 0;
    end
    check64("post_reset_quiet", 64'(quiet), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
